// File: rtl/control_defs.sv
// Shared definitions for the control unit: opcodes, ALU op codes, state
// encoding and the strobe bundle decoded from each state.
package control_defs;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  // Instruction class latched at the end of T2; steers the T3..T7 path.
  typedef enum logic [1:0] {
    K_LD, K_LDI, K_ST, K_ADDI
  } kind_t;

  typedef struct packed {
    logic       run;
    logic       pc_out;
    logic       pc_in;
    logic       inc_pc;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       read;
    logic       write;
    logic       ir_in;
    logic       gra;
    logic       grb;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
    logic       y_in;
    logic       c_out;
    logic       z_in_low;
    logic       z_low_out;
    logic [4:0] operation;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(state_t s, kind_t k);
    ctrl_t c;
    c = '0;
    case (s)
      S_T0: begin
        c.run = 1'b1; c.pc_out = 1'b1; c.mar_in = 1'b1;
        c.inc_pc = 1'b1; c.z_in_low = 1'b1;
      end
      S_T1: begin
        c.run = 1'b1; c.z_low_out = 1'b1; c.pc_in = 1'b1;
        c.read = 1'b1; c.mdr_in = 1'b1;
      end
      S_T2: begin
        c.run = 1'b1; c.mdr_out = 1'b1; c.ir_in = 1'b1;
      end
      S_T3: begin
        c.run = 1'b1; c.grb = 1'b1; c.y_in = 1'b1;
        if (k == K_ADDI) c.r_out = 1'b1;
        else             c.ba_out = 1'b1;
      end
      S_T4: begin
        c.run = 1'b1; c.c_out = 1'b1; c.z_in_low = 1'b1;
        c.operation = ALU_ADD;
      end
      S_T5: begin
        c.run = 1'b1; c.z_low_out = 1'b1;
        if (k == K_LD || k == K_ST) c.mar_in = 1'b1;
        else begin
          c.gra = 1'b1; c.r_in = 1'b1;
        end
      end
      S_T6: begin
        c.run = 1'b1; c.mdr_in = 1'b1;
        if (k == K_ST) begin
          c.gra = 1'b1; c.r_out = 1'b1;
        end else begin
          c.read = 1'b1;
        end
      end
      S_T7: begin
        c.run = 1'b1;
        if (k == K_ST) c.write = 1'b1;
        else begin
          c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Moore control sequencer: fetch (T0..T2), per-opcode execute (T3..T7), HALT.
// Strobes are registered as the decode of the next state, so they track the state register.
module control_unit
  import control_defs::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Gra,
  output logic        Grb,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Yin,
  output logic        Cout,
  output logic        Zin_low,
  output logic        Zlowout,
  output logic [4:0]  operation
);

  state_t     state, nxt_state;
  kind_t      kind, nxt_kind;
  ctrl_t      ctrl;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  always_comb begin
    nxt_state = state;
    nxt_kind  = kind;
    case (state)
      S_RST: nxt_state = S_T0;
      S_T0:  nxt_state = Stop ? S_HALT : S_T1;
      S_T1:  nxt_state = S_T2;
      S_T2: begin
        case (opcode)
          OP_LD:   begin nxt_state = S_T3; nxt_kind = K_LD;   end
          OP_LDI:  begin nxt_state = S_T3; nxt_kind = K_LDI;  end
          OP_ST:   begin nxt_state = S_T3; nxt_kind = K_ST;   end
          OP_ADDI: begin nxt_state = S_T3; nxt_kind = K_ADDI; end
          OP_HALT: nxt_state = S_HALT;
          default: nxt_state = S_T0;
        endcase
      end
      S_T3:   nxt_state = S_T4;
      S_T4:   nxt_state = S_T5;
      S_T5:   nxt_state = (kind == K_LD || kind == K_ST) ? S_T6 : S_T0;
      S_T6:   nxt_state = S_T7;
      S_T7:   nxt_state = S_T0;
      S_HALT: nxt_state = S_HALT;
      default: nxt_state = S_RST;
    endcase
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state <= S_RST;
      kind  <= K_LDI;
      ctrl  <= '0;
    end else begin
      state <= nxt_state;
      kind  <= nxt_kind;
      ctrl  <= decode_ctrl(nxt_state, nxt_kind);
    end
  end

  assign Run       = ctrl.run;
  assign PCout     = ctrl.pc_out;
  assign PCin      = ctrl.pc_in;
  assign IncPC     = ctrl.inc_pc;
  assign MARin     = ctrl.mar_in;
  assign MDRin     = ctrl.mdr_in;
  assign MDRout    = ctrl.mdr_out;
  assign Read      = ctrl.read;
  assign Write     = ctrl.write;
  assign IRin      = ctrl.ir_in;
  assign Gra       = ctrl.gra;
  assign Grb       = ctrl.grb;
  assign Rin       = ctrl.r_in;
  assign Rout      = ctrl.r_out;
  assign BAout     = ctrl.ba_out;
  assign Yin       = ctrl.y_in;
  assign Cout      = ctrl.c_out;
  assign Zin_low   = ctrl.z_in_low;
  assign Zlowout   = ctrl.z_low_out;
  assign operation = ctrl.operation;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clock  input  1  single system clock; all state changes on rising edge.
REQ-002 clear  input  1  asynchronous, active-high reset.
REQ-003 IR  input  32  instruction register contents; opcode = IR[31:27].
REQ-004 Stop  input  1  halt request, sampled only in state T0.
REQ-005 Run  output  1  1 while executing, 0 in reset and halt.
REQ-006 PCout / PCin / IncPC  output  1 each  PC drive-bus / load-from-bus / increment-by-4 strobes.
REQ-007 MARin  output  1  load MAR from bus.
REQ-008 MDRin / MDRout  output  1 each  MDR load / MDR drive-bus.
REQ-009 Read / Write  output  1 each  memory read (MDR takes memory data) / memory write strobe.
REQ-010 IRin  output  1  load IR from bus.
REQ-011 Gra / Grb  output  1 each  select Ra (IR[26:23]) / Rb (IR[22:19]) in the register-select logic.
REQ-012 Rin / Rout / BAout  output  1 each  selected-register load / drive / base-address drive (R0 reads as 0).
REQ-013 Yin / Cout  output  1 each  load Y / drive sign-extended IR[18:0] onto the bus.
REQ-014 Zin_low / Zlowout  output  1 each  load Z low / drive Z low onto the bus.
REQ-015 operation  output  5  ALU op select; ADD = 5'b00011, otherwise 5'b00000.

Function
REQ-016 Moore FSM: outputs decode from the state register only; every state lasts exactly one Clock cycle.
REQ-017 States: RST, T0..T7, HALT; RST -> T0 on the first edge after clear deasserts.
REQ-018 Fetch: T0 {PCout, MARin, IncPC, Zin_low}; T1 {Zlowout, PCin, Read, MDRin}; T2 {MDRout, IRin}.
REQ-019 Opcodes: ld = 00000, ldi = 00001, st = 00010, addi = 01100, nop = 11010, halt = 11011; decode IR in T2 to select the T3 path.
REQ-020 ldi: T3 {Grb, BAout, Yin}; T4 {Cout, operation = ADD, Zin_low}; T5 {Zlowout, Gra, Rin}; then T0 (6 cycles total).
REQ-021 addi: same as ldi except T3 uses Rout instead of BAout.
REQ-022 ld: T3-T4 as ldi; T5 {Zlowout, MARin}; T6 {Read, MDRin}; T7 {MDRout, Gra, Rin}; then T0 (8 cycles).
REQ-023 st: T3-T5 as ld; T6 {Gra, Rout, MDRin} with Read = 0; T7 {Write}; then T0 (8 cycles).
REQ-024 nop, and any undefined opcode, take T2 -> T0 with no side effects.
REQ-025 halt: T2 -> HALT. Stop = 1 in T0: T0 -> HALT, and the T0 strobes are still issued that cycle.
REQ-026 HALT: all strobes 0 and Run = 0; HALT is left only by clear.
REQ-027 At most one bus driver (PCout, Zlowout, MDRout, Rout, BAout, Cout) is high in any state.
REQ-028 Read and Write are never high in the same cycle.

Reset
REQ-029 While clear = 1: state = RST, every output 0 including operation and Run, independent of Clock.
REQ-030 clear asserted mid-instruction aborts it immediately; after release, execution restarts at T0 with no partial strobes.

Structure
REQ-031 A shared package control_defs holds the opcode constants, the ALU op codes and the state encoding, so the datapath and benches reuse them.
REQ-032 Single flat module: a state register plus combinational next-state and output decode; no sub-module.

Verification
REQ-033 Case 1, ldi: IR = 32'h0880_0055 (ldi R1,85(R0)) -> T3 Grb+BAout+Yin, T4 Cout+operation = 00011, T5 Zlowout+Gra+Rin; next cycle T0.
REQ-034 Case 2, ld: IR opcode 00000 -> T5 MARin+Zlowout, T6 Read+MDRin, T7 MDRout+Gra+Rin; 8 cycles from T0 to T0.
REQ-035 Case 3, st: IR opcode 00010 -> T6 Rout+MDRin with Read = 0; Write high only in T7.
REQ-036 Case 4, nop: IR = 32'hD000_0000 -> T2 -> T0 with no Rin or Write.
REQ-037 Case 5, halt and Stop: IR = 32'hD800_0000 -> HALT, Run = 0 and held. Separately, Stop = 1 in T0 -> HALT after one cycle.
REQ-038 Case 6, reset: clear pulsed during ld T6 -> all outputs 0 at once, without waiting for Clock; after release, RST then T0.
